// File: rtl/seq_shifter.sv
// Iterative 8-bit shift/rotate unit: one bit position per clock, registered
// result with carry-out and zero flags and a single-cycle done pulse.
module seq_shifter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [2:0] amt,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic [7:0] y,
    output logic       carry,
    output logic       zero
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic [1:0] state_q, state_d;
    logic [7:0] work_q,  work_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [1:0] op_q,    op_d;
    logic [7:0] y_q,     y_d;
    logic       carry_q, carry_d;
    logic       zero_q,  zero_d;

    logic [7:0] step_val;
    logic       step_out;

    // One 1-bit step of the latched operation on the work register.
    always_comb begin
        step_val = work_q;
        step_out = 1'b0;
        case (op_q)
            OP_LSL: begin step_val = {work_q[6:0], 1'b0};      step_out = work_q[7]; end
            OP_LSR: begin step_val = {1'b0, work_q[7:1]};      step_out = work_q[0]; end
            OP_ASR: begin step_val = {work_q[7], work_q[7:1]}; step_out = work_q[0]; end
            OP_ROL: begin step_val = {work_q[6:0], work_q[7]}; step_out = work_q[7]; end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path
        // through the case below leaves one unassigned and infers a latch.
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        y_d     = y_q;
        carry_d = carry_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = a;
                    cnt_d  = amt;
                    op_d   = op;
                    if (amt != 3'd0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                        y_d     = a;
                        carry_d = 1'b0;
                        zero_d  = (a == 8'h00);
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - 3'd1;
                // The bit shifted out on the final step is the carry-out.
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                    y_d     = step_val;
                    carry_d = step_out;
                    zero_d  = (step_val == 8'h00);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            work_q  <= 8'h00;
            cnt_q   <= 3'd0;
            op_q    <= OP_LSL;
            y_q     <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign y     = y_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [2:0] amt;
    logic [1:0] op;
    logic       busy, done, carry, zero;
    logic [7:0] y;

    int n_pass  = 0;
    int n_total = 0;

    seq_shifter dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .amt(amt), .op(op),
        .busy(busy), .done(done), .y(y), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference result from the arithmetic definition of each operation.
    function automatic void model_shift(input logic [7:0] ia, input int n, input logic [1:0] iop,
                                        output logic [7:0] oy, output logic oc);
        logic [15:0] wide;
        oy = ia;
        oc = 1'b0;
        case (iop)
            2'b00: begin
                wide = {8'h00, ia} << n;
                oy   = wide[7:0];
                if (n > 0) oc = wide[8];
            end
            2'b01: begin
                oy = ia >> n;
                if (n > 0) oc = ia[n-1];
            end
            2'b10: begin
                oy = $signed(ia) >>> n;
                if (n > 0) oc = ia[n-1];
            end
            default: begin
                wide = {ia, ia} << n;
                oy   = wide[15:8];
                if (n > 0) oc = ia[8-n];
            end
        endcase
    endfunction

    // Cycle-level expectation: an accepted op keeps the unit busy for amt+1
    // cycles, the last of which carries done and the new result.
    int         m_left;
    logic [7:0] m_y, p_y;
    logic       m_c, m_z, p_c;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0;
            m_y = 8'h00; m_c = 1'b0; m_z = 1'b0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 1) begin m_y = p_y; m_c = p_c; m_z = (p_y == 8'h00); end
            end else if (start) begin
                model_shift(a, int'(amt), op, p_y, p_c);
                m_left = int'(amt) + 1;
                if (m_left == 1) begin m_y = p_y; m_c = p_c; m_z = (p_y == 8'h00); end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("cmp_busy",  busy,  m_left > 0);
            check("cmp_done",  done,  m_left == 1);
            check("cmp_y",     y,     m_y);
            check("cmp_carry", carry, m_c);
            check("cmp_zero",  zero,  m_z);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done"}, done, 1);
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [2:0] iamt, input logic [1:0] iop,
                          input logic [7:0] ey, input logic ec, input logic ez, input string nm);
        int n;
        wait_idle();
        a = ia; amt = iamt; op = iop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ia; amt = ~iamt; op = ~iop;
        n = 1;
        if (!done) begin
            wait_done(nm, n);
            n++;
        end else check({nm, "_done"}, done, 1);
        check({nm, "_lat"},   n, int'(iamt) + 1);
        check({nm, "_y"},     y, ey);
        check({nm, "_carry"}, carry, ec);
        check({nm, "_zero"},  zero, ez);
    endtask

    initial begin
        logic [7:0] ey;
        logic       ec;
        int         n;
        int         seen;

        reset_n = 1'b0; start = 1'b0; a = 8'h00; amt = 3'd0; op = 2'b00;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y, 8'h00);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Pin the reference model against hand-computed values.
        model_shift(8'h90, 4, 2'b10, ey, ec);
        check("model_asr_y", ey, 8'hF9);
        model_shift(8'h81, 1, 2'b11, ey, ec);
        check("model_rol_y", ey, 8'h03);
        check("model_rol_c", ec, 1);
        model_shift(8'hB5, 3, 2'b00, ey, ec);
        check("model_lsl_y", ey, 8'hA8);

        // Directed vectors.
        run_op(8'hB5, 3'd3, 2'b00, 8'hA8, 1'b1, 1'b0, "lsl_b5_3");
        @(negedge clk);
        check("lsl_b5_3_busy_low", busy, 0);
        run_op(8'h81, 3'd7, 2'b01, 8'h01, 1'b0, 1'b0, "lsr_81_7");
        run_op(8'h90, 3'd4, 2'b10, 8'hF9, 1'b0, 1'b0, "asr_90_4");
        run_op(8'h81, 3'd1, 2'b11, 8'h03, 1'b1, 1'b0, "rol_81_1");
        run_op(8'h3C, 3'd2, 2'b11, 8'hF0, 1'b0, 1'b0, "rol_3c_2");
        run_op(8'h00, 3'd0, 2'b00, 8'h00, 1'b0, 1'b1, "lsl_00_0");
        run_op(8'h80, 3'd1, 2'b00, 8'h00, 1'b1, 1'b1, "lsl_80_1");

        // Start while busy is ignored.
        wait_idle();
        a = 8'hB5; amt = 3'd3; op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h55; amt = 3'd1; op = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign", n);
        check("busy_ign_y", y, 8'hA8);
        check("busy_ign_carry", carry, 1);

        // Start held from the DONE cycle: ignored there, accepted on first idle cycle.
        a = 8'h3C; amt = 3'd2; op = 2'b11; start = 1'b1;
        @(negedge clk);
        check("done_start_ignored", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("idle_start_accepted", busy, 1);
        wait_done("idle_acc", n);
        check("idle_acc_y", y, 8'hF0);
        check("idle_acc_carry", carry, 0);

        // Asynchronous reset in the middle of a long shift.
        wait_idle();
        a = 8'hFF; amt = 3'd7; op = 2'b00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_y", y, 8'h00);
        check("midrst_carry", carry, 0);
        check("midrst_zero", zero, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);
        run_op(8'hB5, 3'd3, 2'b00, 8'hA8, 1'b1, 1'b0, "post_rst");

        // Exhaustive sweep against the reference model.
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 8; s++) begin
                for (int v = 0; v < 256; v++) begin
                    model_shift(8'(v), s, 2'(o), ey, ec);
                    run_op(8'(v), 3'(s), 2'(o), ey, ec, ey == 8'h00, "sweep");
                end
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
